apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester bridging a simple valid/ready command interface onto the APB bus: SETUP and ACCESS phases, PREADY wait states, single-entry response.
- Sits between a local controller or bench driver and any APB completer on the bus, including the team's apb_slave memory.
- One transfer in flight at a time.
- Bounded wait: an ACCESS phase that never sees PREADY is aborted with an error response.

Parameters:
- DW, 32, data width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- AW, 32, address width of PADDR/cmd_addr.
- TIMEOUT, 16, max ACCESS-phase cycles without PREADY before abort; must be >= 2.

Ports:
- PCLK  in  1  clock; all state changes on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  transfer address.
- cmd_wdata  in  DW  write data; ignored for reads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR seen or timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB error; tie 0 if the completer has none.

Behaviour:
- Reset (async on PRESETn low, any state): state IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid, rsp_err = 0; rsp_rdata = 0.
  - Timeout counter = 0.
  - Reset mid-transfer aborts silently; no response is produced.
- All outputs registered. cmd_ready = (state == IDLE), the only combinational output.
- FSM states IDLE, SETUP, ACCESS, RESP:
  - IDLE: on cmd_valid && cmd_ready, latch write/addr/wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
  - SETUP (exactly 1 cycle): PSEL = 1, PENABLE = 0, then go to ACCESS.
  - ACCESS: PSEL = 1, PENABLE = 1. Counter increments every cycle PREADY = 0.
    - PREADY = 1: capture rsp_rdata = PRDATA if read else 0, rsp_err = PSLVERR. Deassert PSEL/PENABLE and set rsp_valid = 1 on the next edge. Go to RESP.
    - Counter reaches TIMEOUT - 1 with PREADY still 0: same exit with rsp_err = 1, rsp_rdata = 0.
    - PREADY wins if it arrives on the timeout cycle.
  - RESP: rsp_valid held until rsp_ready = 1. On acceptance clear rsp_valid, return to IDLE, clear counter.
- Control-signal rules:
  - PADDR/PWRITE/PWDATA stable from SETUP through the end of ACCESS.
  - After a transfer, PADDR/PWDATA keep their last values; PWRITE keeps its last value.
  - PSEL is never high in IDLE or RESP, so every transfer has a fresh SETUP cycle.
  - No back-to-back ACCESS.
- Latency (cmd accepted at edge N):
  - SETUP during N+1, ACCESS from N+2.
  - Zero-wait completer: rsp_valid high at N+3.
  - Minimum command-to-command spacing: 4 cycles when rsp_ready is held 1.
  - Each PREADY wait cycle adds one cycle.
- Commands presented while cmd_ready = 0 are ignored, not queued. The requester must hold cmd_valid.
- Unaligned addresses are passed through unmodified.

Decomposition:
- Package apb_pkg:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS, RESP};
  - typedef struct apb_cmd_t {write, addr, wdata};
  - localparam for default TIMEOUT.
- Single module; no sub-module needed. The timeout counter is inline, $clog2(TIMEOUT) bits.

Test Plan:
- Write then read, zero-wait completer: write addr 0x4, data 0xDEADBEEF, then read addr 0x4.
  - Required: rsp_rdata = 0xDEADBEEF, rsp_err = 0.
  - SETUP/ACCESS phase order checked.
  - Read rsp_valid 3 cycles after acceptance.
- Wait states: completer asserts PREADY after 3 ACCESS cycles.
  - Required: PSEL/PENABLE/PADDR stable throughout; rsp_valid 6 cycles after acceptance.
- Timeout: PREADY tied 0, TIMEOUT = 16.
  - Required: ACCESS lasts exactly 16 cycles; rsp_err = 1, rsp_rdata = 0; PSEL drops; next command accepted normally.
- Slave error: PSLVERR = 1 with PREADY on a read of 0x8.
  - Required: rsp_err = 1, rsp_rdata = 0x00000000.
- Response backpressure: rsp_ready held 0 for 5 cycles.
  - Required: rsp_valid and rsp_rdata held; cmd_ready = 0; PSEL = 0; second cmd_valid not accepted until after rsp_ready.
- Reset mid-ACCESS: assert PRESETn = 0 asynchronously.
  - Required: PSEL, PENABLE, rsp_valid = 0 immediately; no response after release; cmd_ready = 1 on first cycle out of reset.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, command bundle and defaults for the APB requester.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_t;
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_cmd_t;
    localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/apb_master.sv
// apb_master: valid/ready command to APB requester, one transfer in flight, bounded ACCESS wait.
// Ports: PCLK/PRESETn clock and async active-low reset; cmd_* command channel (cmd_ready high only
// in IDLE); rsp_* single-entry response (rdata zero for writes and errors, err on PSLVERR or
// timeout); PSEL/PENABLE/PWRITE/PADDR/PWDATA registered APB request; PRDATA/PREADY/PSLVERR completer.
module apb_master
    import apb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [DW-1:0] PWDATA,
    input  logic [DW-1:0] PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    apb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d  = SETUP;
                psel_d   = 1'b1;
                pwrite_d = cmd_write;
                paddr_d  = cmd_addr;
                pwdata_d = cmd_wdata;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            // PREADY takes priority over the timeout on the last allowed cycle
            ACCESS: if (PREADY || cnt_q == CNT_LAST) begin
                state_d     = RESP;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = PREADY ? PSLVERR : 1'b1;
                rdata_d     = (PREADY && !PSLVERR && !pwrite_q) ? PRDATA : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
